// File: rtl/video_cfg_pkg.sv
// ============================================================================
// video_cfg_pkg : shared types and constants for the video configuration controller
// Rev 1.0
// ============================================================================
`default_nettype none

package video_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_SKIP = 3'd4
  } state_t;

  localparam logic [7:0] CMD_CFG   = 8'h30;

  localparam logic [2:0] REG_SCAN  = 3'd0;
  localparam logic [2:0] REG_VOL   = 3'd1;
  localparam logic [2:0] REG_WIDE  = 3'd2;
  localparam logic [2:0] REG_DIVLO = 3'd3;
  localparam logic [2:0] REG_DIVHI = 3'd4;

  localparam logic [1:0] DEF_SCAN   = 2'd0;
  localparam logic [1:0] DEF_VOL    = 2'd2;
  localparam logic       DEF_WIDE   = 1'b0;
  localparam logic       DEF_MANUAL = 1'b0;
  localparam logic [7:0] DEF_DIV_LO = 8'd0;
  localparam logic       DEF_DIV_HI = 1'b0;

  localparam logic [8:0] DIV_PAL  = 9'd326;
  localparam logic [8:0] DIV_NTSC = 9'd342;

endpackage

`default_nettype wire

// File: rtl/video_cfg_ctrl.sv
// ============================================================================
// video_cfg_ctrl : MCU command parser with frame-synchronous commit of video/audio controls
// Rev 1.0
// ============================================================================
`default_nettype none

module video_cfg_ctrl #(
  parameter logic [7:0] CMD_CFG  = video_cfg_pkg::CMD_CFG,
  parameter logic [8:0] DIV_PAL  = video_cfg_pkg::DIV_PAL,
  parameter logic [8:0] DIV_NTSC = video_cfg_pkg::DIV_NTSC
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       mcu_start,
  input  logic       mcu_strobe,
  input  logic [7:0] mcu_data,
  input  logic       vs_in_n,
  input  logic       ntscmode,
  output logic [1:0] system_scanlines,
  output logic [1:0] system_volume,
  output logic       system_wide_screen,
  output logic [8:0] audio_div,
  output logic       cfg_pending
);

  import video_cfg_pkg::*;

  state_t     state;
  logic [2:0] index;
  logic       index_ok;
  logic [1:0] sh_scan;
  logic [1:0] sh_vol;
  logic       sh_wide;
  logic [7:0] sh_div_lo;
  logic       sh_div_hi;
  logic       sh_manual;
  logic       pending;

  logic       vs_d;
  logic       frame_pulse;
  logic [1:0] vol_live;
  logic       manual_live;
  logic       manual_next;
  logic       write_hit;

  assign write_hit   = index_ok && (index <= REG_DIVHI);
  assign manual_next = frame_pulse ? sh_manual : manual_live;
  assign cfg_pending = pending || (system_volume != vol_live);

  // Command parser and shadow registers; start always wins over a coincident strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      index     <= 3'd0;
      index_ok  <= 1'b0;
      sh_scan   <= DEF_SCAN;
      sh_vol    <= DEF_VOL;
      sh_wide   <= DEF_WIDE;
      sh_div_lo <= DEF_DIV_LO;
      sh_div_hi <= DEF_DIV_HI;
      sh_manual <= DEF_MANUAL;
      pending   <= 1'b0;
    end else begin
      if (frame_pulse)
        pending <= 1'b0;
      if (mcu_start) begin
        state <= ST_CMD;
      end else if (mcu_strobe) begin
        case (state)
          ST_CMD:  state <= (mcu_data == CMD_CFG) ? ST_ADDR : ST_SKIP;
          ST_ADDR: begin
            index    <= mcu_data[2:0];
            index_ok <= (mcu_data[7:3] == 5'd0);
            state    <= ST_DATA;
          end
          ST_DATA: begin
            state <= ST_ADDR;
            // A write racing the commit must survive it, so it is assigned last.
            if (write_hit) begin
              pending <= 1'b1;
              case (index)
                REG_SCAN:  sh_scan   <= mcu_data[1:0];
                REG_VOL:   sh_vol    <= mcu_data[1:0];
                REG_WIDE:  sh_wide   <= mcu_data[0];
                REG_DIVLO: sh_div_lo <= mcu_data;
                default: begin
                  sh_div_hi <= mcu_data[0];
                  sh_manual <= mcu_data[7];
                end
              endcase
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

  // Frame-edge detect, commit, volume ramp and audio divisor selection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_d               <= 1'b1;
      frame_pulse        <= 1'b0;
      system_scanlines   <= DEF_SCAN;
      system_volume      <= 2'd0;
      system_wide_screen <= DEF_WIDE;
      vol_live           <= DEF_VOL;
      manual_live        <= DEF_MANUAL;
      audio_div          <= DIV_PAL;
    end else begin
      vs_d        <= vs_in_n;
      frame_pulse <= vs_in_n && !vs_d;
      if (frame_pulse) begin
        system_scanlines   <= sh_scan;
        system_wide_screen <= sh_wide;
        vol_live           <= sh_vol;
        manual_live        <= sh_manual;
        if (system_volume < sh_vol)
          system_volume <= system_volume + 2'd1;
        else if (system_volume > sh_vol)
          system_volume <= system_volume - 2'd1;
      end
      if (!manual_next)
        audio_div <= ntscmode ? DIV_NTSC : DIV_PAL;
      else if (frame_pulse)
        audio_div <= {sh_div_hi, sh_div_lo};
    end
  end

endmodule

`default_nettype wire
